// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-port SRAM between fetch and data requesters
module sram_port_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // MAX_DATA_RUN must be 1..7 so the limit fits the 3-bit run counter
    localparam logic [2:0] RUN_MAX = 3'(MAX_DATA_RUN);

    logic [2:0] run_cnt;
    logic       rsp_valid;
    logic       rsp_owner;   // 1 = data, 0 = inst
    logic       grant_inst;
    logic       grant_data;
    logic       inst_starved;

    assign inst_starved = inst_req && (run_cnt == RUN_MAX);

    // Data has priority unless fetch has waited out its run budget; nothing is granted in reset
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn) begin
            if (data_req && !inst_starved) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    assign mem_en    = grant_inst | grant_data;
    assign mem_addr  = grant_data ? data_addr : inst_addr;
    assign mem_we    = (grant_data && data_wr) ? data_wstrb : 4'b0000;
    assign mem_wdata = data_wdata;

    // Count data grants that bypassed a waiting fetch; any fetch grant or idle fetch restarts it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_cnt <= 3'd0;
        end else if (grant_inst || !inst_req) begin
            run_cnt <= 3'd0;
        end else if (grant_data && (run_cnt != RUN_MAX)) begin
            run_cnt <= run_cnt + 3'd1;
        end
    end

    // Remember who owns the SRAM access in flight so its response lands on the right port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            rsp_valid <= mem_en;
            rsp_owner <= grant_data;
        end
    end

    assign inst_data_ok = rsp_valid & ~rsp_owner;
    assign data_data_ok = rsp_valid & rsp_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        tb_init;
    logic [31:0] sram [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Synchronous single-port SRAM: byte-write, registered read, indexed by addr[11:2]
    always @(posedge clk) begin
        if (tb_init) begin
            sram[0]   <= 32'h0A0B0C01;
            sram[1]   <= 32'h0A0B0C02;
            sram[2]   <= 32'h0A0B0C03;
            sram[16]  <= 32'h11223344;
            sram[64]  <= 32'hC0DE0100;
            sram[128] <= 32'hDA7A0200;
        end else if (mem_en) begin
            mem_rdata <= sram[mem_addr[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) sram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [31:0] fetch_words [0:2];

    initial begin
        fetch_words[0] = 32'h0A0B0C01;
        fetch_words[1] = 32'h0A0B0C02;
        fetch_words[2] = 32'h0A0B0C03;

        resetn = 1'b0; tb_init = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        next_cycle();
        tb_init = 1'b0;

        // reset: requests present but everything forced idle
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h200;
        sample();
        check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        check("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        check("rst_mem_en",       {31'b0, mem_en}, 32'd0);
        check("rst_mem_we",       {28'b0, mem_we}, 32'd0);
        check("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
        check("rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
        next_cycle();
        resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;

        // inst-only back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            inst_req  = (i < 3);
            inst_addr = 32'h1c000000 + 32'(4 * i);
            sample();
            if (i < 3) begin
                check("if_addr_ok",  {31'b0, inst_addr_ok}, 32'd1);
                check("if_mem_addr", mem_addr, 32'h1c000000 + 32'(4 * i));
            end else begin
                check("if_idle_mem_en", {31'b0, mem_en}, 32'd0);
            end
            if (i > 0) begin
                check("if_data_ok", {31'b0, inst_data_ok}, 32'd1);
                check("if_rdata",   inst_rdata, fetch_words[i - 1]);
            end else begin
                check("if_first_data_ok", {31'b0, inst_data_ok}, 32'd0);
            end
        end

        // simultaneous reads: data first, then inst
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200;
        sample();
        check("both_data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
        check("both_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        check("both_mem_addr",     mem_addr, 32'h200);
        next_cycle();
        data_req = 1'b0;
        sample();
        check("both_inst_addr_ok2", {31'b0, inst_addr_ok}, 32'd1);
        check("both_data_data_ok",  {31'b0, data_data_ok}, 32'd1);
        check("both_data_rdata",    data_rdata, 32'hDA7A0200);
        next_cycle();
        inst_req = 1'b0;
        sample();
        check("both_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("both_data_ok_low",  {31'b0, data_data_ok}, 32'd0);
        check("both_inst_rdata",   inst_rdata, 32'hC0DE0100);

        // starvation guard: D,D,D,D,I repeating
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        data_req = 1'b1; data_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("starve_data_grant", {31'b0, data_addr_ok}, (i % 5 == 4) ? 32'd0 : 32'd1);
            check("starve_inst_grant", {31'b0, inst_addr_ok}, (i % 5 == 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        inst_req = 1'b0; data_req = 1'b0;
        next_cycle();

        // partial write then read-back of the merged word
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h40;
        data_wstrb = 4'b0011; data_wdata = 32'hAABBCCDD;
        sample();
        check("wr_addr_ok",  {31'b0, data_addr_ok}, 32'd1);
        check("wr_mem_we",   {28'b0, mem_we}, 32'h3);
        check("wr_mem_addr", mem_addr, 32'h40);
        check("wr_mem_wdata", mem_wdata, 32'hAABBCCDD);
        next_cycle();
        data_wr = 1'b0; data_wstrb = 4'h0;
        sample();
        check("wr_data_ok",   {31'b0, data_data_ok}, 32'd1);
        check("rd_addr_ok",   {31'b0, data_addr_ok}, 32'd1);
        check("rd_mem_we",    {28'b0, mem_we}, 32'd0);
        next_cycle();
        data_req = 1'b0;
        sample();
        check("rd_data_ok", {31'b0, data_data_ok}, 32'd1);
        check("rd_rdata",   data_rdata, 32'h1122CCDD);

        // reset mid-run: in-flight response dropped, run counter restarts
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        data_req = 1'b1; data_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("pre_rst_data_grant", {31'b0, data_addr_ok}, 32'd1);
            next_cycle();
        end
        resetn = 1'b0;
        sample();
        check("mid_rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
        check("mid_rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        check("mid_rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        check("mid_rst_mem_en",       {31'b0, mem_en}, 32'd0);
        next_cycle();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i == 0) check("post_rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
            check("post_rst_data_grant", {31'b0, data_addr_ok}, (i == 4) ? 32'd0 : 32'd1);
            check("post_rst_inst_grant", {31'b0, inst_addr_ok}, (i == 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        inst_req = 1'b0; data_req = 1'b0;
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h1c000004;
        sample();
        check("post_rst_fetch_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
        next_cycle();
        inst_req = 1'b0;
        sample();
        check("post_rst_fetch_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("post_rst_fetch_rdata",   inst_rdata, 32'h0A0B0C02);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and the data-access requester, replacing separate inst/data SRAMs. Sits between the IF/EX/MA stages and the memory. It converts the SRAMs' fixed-latency interface into a req/addr_ok/data_ok handshake per requester, and issues at most one access per cycle. Arbitration is data-priority with a bounded starvation guard for fetch.

## Interface
- MAX_DATA_RUN, 4, consecutive data grants allowed while inst_req is pending before inst is forced a grant (1..7)
- clk  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch data
- data_req  in  1  data request; held with wr/wstrb/addr/wdata until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte enables for writes
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read data valid / write complete this cycle
- data_rdata  out  32  read data
- mem_en  out  1  SRAM enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  32  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after the enabled read

## Operation
- Grant (combinational, each cycle):
  - data_req only -> data; inst_req only -> inst.
  - Both present -> data, unless run_cnt == MAX_DATA_RUN, then inst.
- inst_addr_ok = inst granted; data_addr_ok = data granted; never both high.
- Memory drive:
  - mem_en = inst_addr_ok | data_addr_ok.
  - mem_addr = granted requester's address.
  - mem_we = data_wstrb when data granted with data_wr = 1, else 0.
  - mem_wdata = data_wdata.
- run_cnt, 3-bit register:
  - increments (saturating at MAX_DATA_RUN) when data is granted while inst_req = 1;
  - clears when inst is granted or inst_req = 0.
- Response tracking registers, loaded every cycle:
  - rsp_valid <= mem_en; rsp_owner <= 1 for data, 0 for inst.
- Responses:
  - inst_data_ok = rsp_valid & ~rsp_owner.
  - data_data_ok = rsp_valid & rsp_owner; writes also return data_ok.
  - inst_rdata = data_rdata = mem_rdata, passed unregistered. Content is meaningful only when the matching data_ok is high, and undefined on write responses.
- Requesters accept data_ok unconditionally; the block has no response backpressure.
- A requester may issue a new request in the same cycle it receives data_ok. Back-to-back issue at 1 access/cycle is supported.

## Timing
- Issue latency: addr_ok in the same cycle as req when granted (0 cycles).
- Response latency: data_ok exactly 1 cycle after addr_ok.
- Throughput: one access per cycle total, shared between both requesters.
- Reset (resetn low, asynchronous):
  - rsp_valid = 0, run_cnt = 0.
  - inst_data_ok and data_data_ok are 0 immediately.
  - addr_ok outputs and mem_en/mem_we follow req combinationally. While in reset, both are forced to 0.
  - An access whose addr_ok occurred in the cycle reset asserts gets no data_ok.
- Boundary conditions:
  - Simultaneous req on the cycle run_cnt hits MAX_DATA_RUN -> inst wins; run_cnt clears the next edge.
  - Data write and inst fetch to the same address in consecutive cycles are serialized by grant order; a read granted after a write returns the new data.
  - MAX_DATA_RUN is fixed at elaboration; a value of 0 is illegal.

## Test plan
- Inst only, inst_req held high with addresses 0x1c000000, +4, +8 -> addr_ok every cycle; data_ok one cycle later with the preloaded words, in order.
- Both requesters assert a read in the same cycle (inst 0x100, data 0x200) -> data_addr_ok first; inst_addr_ok next cycle; data_data_ok then inst_data_ok on consecutive cycles with the correct words.
- Starvation, MAX_DATA_RUN = 4: data_req high continuously and inst_req high -> grant pattern D,D,D,D,I repeating; inst is never stalled more than 4 cycles.
- Write data_addr 0x40, wstrb 4'b0011, wdata 0xAABBCCDD over preload 0x11223344, then read 0x40 -> mem_we = 0011; write data_data_ok after 1 cycle; read returns 0x1122CCDD.
- Assert resetn low in the cycle after data_addr_ok -> data_data_ok stays 0, run_cnt = 0. After release, a new inst fetch completes normally.
